// File: rtl/multiplier_8b_pkg.sv
// Shared widths for the 8x8 array multiplier.
package multiplier_8b_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
endpackage

// File: rtl/multiplier_8b_fa_cell.sv
// 1-bit full adder cell; used as a half adder by tying cin_i low.
module mult_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/multiplier_8b.sv
// Unsigned 8x8 array multiplier: AND partial products reduced by ripple adder rows,
// with a combinational product and a one-cycle registered copy plus valid.
module multiplier_8b
  import multiplier_8b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   a_in,
  input  logic [OP_W-1:0]   b_in,
  input  logic              in_valid,
  output logic [PROD_W-1:0] prod,
  output logic [PROD_W-1:0] prod_q,
  output logic              out_valid
);
  logic [OP_W-1:0][OP_W-1:0] pp;    // pp[i][j] = a[j] & b[i]
  logic [OP_W-1:0][OP_W-1:0] acc;   // running upper bits after row i
  logic [OP_W-1:1][OP_W-1:0] rsum;
  logic [OP_W-1:1][OP_W:0]   rcar;

  for (genvar i = 0; i < OP_W; i++) begin : g_pp_row
    for (genvar j = 0; j < OP_W; j++) begin : g_pp_col
      assign pp[i][j] = a_in[j] & b_in[i];
    end
  end

  // Row 0 needs no adder: its LSB is final, the rest seeds the accumulator.
  assign prod[0] = pp[0][0];
  assign acc[0]  = {1'b0, pp[0][OP_W-1:1]};

  for (genvar i = 1; i < OP_W; i++) begin : g_row
    assign rcar[i][0] = 1'b0;
    for (genvar j = 0; j < OP_W; j++) begin : g_cell
      mult_fa_cell u_fa (
        .a_i   (acc[i-1][j]),
        .b_i   (pp[i][j]),
        .cin_i (rcar[i][j]),
        .sum_o (rsum[i][j]),
        .cout_o(rcar[i][j+1])
      );
    end
    assign prod[i] = rsum[i][0];
    assign acc[i]  = {rcar[i][OP_W], rsum[i][OP_W-1:1]};
  end

  assign prod[PROD_W-1:OP_W] = acc[OP_W-1];

  logic [PROD_W-1:0] prod_d;
  logic              out_valid_d;

  always_comb begin
    prod_d      = prod_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      prod_d      = prod;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      out_valid <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_multiplier_8b.sv
// Self-checking bench for multiplier_8b: directed cases, random traffic, exhaustive sweep.
module tb_multiplier_8b;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_in, b_in;
  logic        in_valid;
  logic [15:0] prod, prod_q;
  logic        out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_prod = 16'h0;
  logic        m_vld  = 1'b0;

  multiplier_8b dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_valid (in_valid),
    .prod     (prod),
    .prod_q   (prod_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: registered product of the last accepted pair, cleared by reset.
  always @(posedge clk) begin
    if (rst) begin
      m_prod = 16'h0;
      m_vld  = 1'b0;
    end else if (in_valid) begin
      m_prod = 16'(int'(a_in) * int'(b_in));
      m_vld  = 1'b1;
    end else begin
      m_vld  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, check comb product, then check the register after the edge.
  task automatic apply(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst = r; in_valid = v; a_in = a; b_in = b;
    #1;
    chk("prod", prod, int'(a) * int'(b));
    @(posedge clk);
    #1;
    chk("prod_q", prod_q, m_prod);
    chk("out_valid", out_valid, m_vld);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a_in = 8'd0; b_in = 8'd0;

    // Reset held with a qualified pair present
    apply(1'b1, 1'b1, 8'd25, 8'd93);
    apply(1'b1, 1'b1, 8'd25, 8'd93);
    chk("rst_prod_q", prod_q, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("comb_25x93", prod, 32'h0915);
    apply(1'b0, 1'b1, 8'd25, 8'd93);
    chk("post_rst_prod_q", prod_q, 32'd2325);
    chk("post_rst_valid", out_valid, 32'd1);

    // Back-to-back pair, then idle holds value
    apply(1'b0, 1'b1, 8'd25, 8'd87);
    chk("b2b_prod_q", prod_q, 32'd2175);
    chk("b2b_valid", out_valid, 32'd1);
    apply(1'b0, 1'b0, 8'd3, 8'd4);
    chk("hold_prod_q", prod_q, 32'd2175);
    chk("hold_valid", out_valid, 32'd0);

    // Corner operands
    apply(1'b0, 1'b1, 8'd0, 8'd0);
    chk("zero", prod_q, 32'd0);
    apply(1'b0, 1'b1, 8'd255, 8'd1);
    chk("255x1", prod_q, 32'd255);
    apply(1'b0, 1'b1, 8'd1, 8'd255);
    chk("1x255", prod_q, 32'd255);
    apply(1'b0, 1'b1, 8'd255, 8'd255);
    chk("255x255", prod_q, 32'hFE01);

    // Reset mid-stream discards the pending capture
    apply(1'b0, 1'b1, 8'd25, 8'd93);
    apply(1'b1, 1'b1, 8'd25, 8'd87);
    chk("mid_rst_prod_q", prod_q, 32'd0);
    chk("mid_rst_valid", out_valid, 32'd0);
    apply(1'b0, 1'b0, 8'd25, 8'd87);
    chk("mid_rst_idle", out_valid, 32'd0);

    // Random traffic with sparse resets and random valid
    for (int k = 0; k < 400; k++)
      apply(($urandom_range(0, 31) == 0), $urandom_range(0, 1),
            8'($urandom), 8'($urandom));

    // Exhaustive sweep, one pair per cycle
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        apply(1'b0, 1'b1, 8'(a), 8'(b));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
